// File: rtl/float_to_signed_int_seq.sv
// Multi-cycle IEEE-754 single to int32 converter with an iterative barrel shifter.
// Define FTOI_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module float_to_signed_int_seq #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] FP_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] signed_int_val,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] STEP_C = 6'(SHIFT_STEP);

    state_t      state_r;
    state_t      state_next_s;

    logic [7:0]  exp_s;
    logic [22:0] mant_s;
    logic        idle_s;
    logic        accept_s;
    logic        special_s;
    logic [31:0] spec_val_s;
    logic        spec_ovf_s;
    logic        left_s;
    logic [5:0]  count_s;

    logic [31:0] mag_r;
    logic [5:0]  rem_r;
    logic        left_r;
    logic        sign_r;
    logic [31:0] result_r;
    logic        ovf_r;
    logic        out_valid_r;

    logic [5:0]  amt_s;
    logic [31:0] left_val_s;
    logic [31:0] right_val_s;
    logic [31:0] mag_rnd_s;

`ifdef FTOI_RNE_EN
    logic        guard_r;
    logic        sticky_r;
    logic [31:0] lost_s;
    logic        round_up_s;
`endif

    assign exp_s    = FP_val[30:23];
    assign mant_s   = FP_val[22:0];
    assign idle_s   = (state_r == IDLE);
    assign accept_s = in_valid && idle_s;

    // Classify the incoming operand: special results bypass the shifter entirely.
    always_comb begin
        special_s  = 1'b0;
        spec_val_s = 32'd0;
        spec_ovf_s = 1'b0;
        left_s     = 1'b0;
        count_s    = 6'd0;
        if (exp_s == 8'd0) begin
            special_s = 1'b1;
        end else if ((exp_s == 8'd255) && (mant_s != 23'd0)) begin
            special_s  = 1'b1;
            spec_ovf_s = 1'b1;
        end else if (exp_s >= 8'd158) begin
            // Magnitude >= 2^31 (or infinite); only -2^31 itself is representable.
            special_s = 1'b1;
            if (!FP_val[31]) begin
                spec_val_s = 32'h7FFF_FFFF;
                spec_ovf_s = 1'b1;
            end else begin
                spec_val_s = 32'h8000_0000;
                spec_ovf_s = (FP_val != 32'hCF00_0000);
            end
        end else if (exp_s < 8'd127) begin
            special_s = 1'b1;
`ifdef FTOI_RNE_EN
            // |x| in [0.5,1): exactly 0.5 ties to 0, anything larger rounds to +-1.
            if ((exp_s == 8'd126) && (mant_s != 23'd0)) begin
                spec_val_s = FP_val[31] ? 32'hFFFF_FFFF : 32'd1;
            end else begin
                spec_val_s = 32'd0;
            end
`endif
        end else if (exp_s > 8'd150) begin
            left_s  = 1'b1;
            count_s = 6'(exp_s - 8'd150);
        end else begin
            left_s  = 1'b0;
            count_s = 6'(8'd150 - exp_s);
        end
    end

    // One step of the barrel shifter plus the rounding increment.
    always_comb begin
        amt_s       = (rem_r < STEP_C) ? rem_r : STEP_C;
        left_val_s  = mag_r << amt_s;
        right_val_s = mag_r >> amt_s;
`ifdef FTOI_RNE_EN
        lost_s      = 32'({mag_r, 32'd0} >> amt_s);
        round_up_s  = guard_r && (sticky_r || mag_r[0]);
        mag_rnd_s   = mag_r + 32'(round_up_s);
`else
        mag_rnd_s   = mag_r;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_next_s = IDLE;
                end else if (special_s) begin
                    state_next_s = DONE;
                end else if (count_s == 6'd0) begin
                    state_next_s = SIGN;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            SHIFT: begin
                if (rem_r <= STEP_C) begin
                    state_next_s = SIGN;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            SIGN: state_next_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready       = idle_s;
        out_valid      = out_valid_r;
        signed_int_val = result_r;
        ovf            = ovf_r;
    end

    // Operand capture, shifting, sign application and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r       <= 32'd0;
            rem_r       <= 6'd0;
            left_r      <= 1'b0;
            sign_r      <= 1'b0;
            result_r    <= 32'd0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef FTOI_RNE_EN
            guard_r     <= 1'b0;
            sticky_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sign_r   <= FP_val[31];
                        mag_r    <= {8'd0, 1'b1, mant_s};
                        rem_r    <= count_s;
                        left_r   <= left_s;
`ifdef FTOI_RNE_EN
                        guard_r  <= 1'b0;
                        sticky_r <= 1'b0;
`endif
                        if (special_s) begin
                            result_r    <= spec_val_s;
                            ovf_r       <= spec_ovf_s;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    rem_r <= rem_r - amt_s;
                    if (left_r) begin
                        mag_r <= left_val_s;
                    end else begin
                        mag_r    <= right_val_s;
`ifdef FTOI_RNE_EN
                        guard_r  <= lost_s[31];
                        sticky_r <= sticky_r | guard_r | (|lost_s[30:0]);
`endif
                    end
                end
                SIGN: begin
                    result_r    <= sign_r ? (32'd0 - mag_rnd_s) : mag_rnd_s;
                    ovf_r       <= 1'b0;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_signed_int_seq.sv
// Scoreboard bench for float_to_signed_int_seq; expectations follow FTOI_RNE_EN when defined.
module tb_float_to_signed_int_seq;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] FP_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] signed_int_val;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] fp;
        logic [31:0] val;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    float_to_signed_int_seq #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .FP_val(FP_val), .out_valid(out_valid), .out_ready(out_ready),
        .signed_int_val(signed_int_val), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) p = p * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) p = p / 2.0;
        end
        return p;
    endfunction

    // Real-valued reference: saturating conversion, truncating or nearest-even.
    function automatic void ref_model(input logic [31:0] fp, output logic [31:0] v,
                                      output logic o, output int lat);
        int     e;
        int     n;
        real    r;
        longint t;
`ifdef FTOI_RNE_EN
        real    fr;
`endif
        e = int'(fp[30:23]);
        v = 32'd0;
        o = 1'b0;
        lat = 1;
        if (e == 0) begin
            v = 32'd0;
        end else if (e == 255 && fp[22:0] != 23'd0) begin
            o = 1'b1;
        end else begin
            r = (8388608.0 + real'(fp[22:0])) * pow2(e - 150);
            if (fp[31]) r = -r;
            if (r >= 2147483648.0) begin
                v = 32'h7FFF_FFFF; o = 1'b1;
            end else if (r < -2147483648.0) begin
                v = 32'h8000_0000; o = 1'b1;
            end else if (r == -2147483648.0) begin
                v = 32'h8000_0000; o = 1'b0;
            end else begin
                t = longint'($rtoi(r));
`ifdef FTOI_RNE_EN
                fr = r - real'(t);
                if (fr < 0.0) fr = -fr;
                if (fr > 0.5 || (fr == 0.5 && t[0])) t = (r < 0.0) ? t - 1 : t + 1;
`endif
                v = 32'(t);
                if (e >= 127) begin
                    n = (e > 150) ? e - 150 : 150 - e;
                    lat = (n + STEP - 1) / STEP + 2;
                end
            end
        end
    endfunction

    task automatic send(input logic [31:0] fp, input logic [31:0] ev, input logic eo, input int lat);
        int   w;
        exp_t e;
        w = 0;
        in_valid = 1'b1;
        FP_val = fp;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%08h]: in_ready %0d expected 1", fp, in_ready);
            in_valid = 1'b0;
        end else begin
            e.fp = fp; e.val = ev; e.ovf = eo; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
            tick();
            in_valid = 1'b0;
            FP_val = $urandom();
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            tick();
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops the scoreboard on every completed output handshake.
    initial begin : monitor
        exp_t e;
        bit   prev_valid;
        int   first_cyc;
        prev_valid = 1'b0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) first_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %08h expected none", signed_int_val);
                    end else begin
                        e = sb.pop_front();
                        check32($sformatf("value[%08h]", e.fp), signed_int_val, e.val);
                        check32($sformatf("ovf[%08h]", e.fp), {31'd0, ovf}, {31'd0, e.ovf});
                        check32($sformatf("latency[%08h]", e.fp), 32'(first_cyc - e.acc), 32'(e.lat));
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] rv;
        logic        ro;
        int          rl;
        logic [31:0] fp;
        int          w;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; FP_val = 32'd0;
        tick(); tick(); tick();
        check32("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check32("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check32("reset_value", signed_int_val, 32'd0);
        check32("reset_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        tick();

        // 1.0: in_ready must stay low for the whole operation
        send(32'h3F80_0000, 32'h0000_0001, 1'b0, 8);
        w = 0;
        while (!out_valid && w < 20) begin
            check32("busy_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            w++;
        end
        drain();

        send(32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 8);
`ifdef FTOI_RNE_EN
        send(32'h4060_0000, 32'h0000_0004, 1'b0, 8);
        send(32'h3FC0_0000, 32'h0000_0002, 1'b0, 8);
        send(32'hBF40_0000, 32'hFFFF_FFFF, 1'b0, 1);
`else
        send(32'h4060_0000, 32'h0000_0003, 1'b0, 8);
        send(32'h3FC0_0000, 32'h0000_0001, 1'b0, 8);
        send(32'hBF40_0000, 32'h0000_0000, 1'b0, 1);
`endif
        send(32'h4020_0000, 32'h0000_0002, 1'b0, 8);
        send(32'h3F00_0000, 32'h0000_0000, 1'b0, 1);
        send(32'h4E80_0000, 32'h4000_0000, 1'b0, 4);
        send(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 4);
        send(32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 4);
        send(32'h4B00_0000, 32'h0080_0000, 1'b0, 2);
        send(32'hCF00_0000, 32'h8000_0000, 1'b0, 1);
        send(32'hCF00_0001, 32'h8000_0000, 1'b1, 1);
        send(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1);
        send(32'h4F32_D05E, 32'h7FFF_FFFF, 1'b1, 1);
        send(32'hFF80_0000, 32'h8000_0000, 1'b1, 1);
        send(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1);
        send(32'h7FC0_0000, 32'h0000_0000, 1'b1, 1);
        send(32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        drain();

        // Backpressure: result held, new operands ignored while busy
        out_ready = 1'b0;
        send(32'h42F6_0000, 32'h0000_007B, 1'b0, 7);
        w = 0;
        while (!out_valid && w < 30) begin
            tick();
            w++;
        end
        check32("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            FP_val = 32'h3F80_0000;
            tick();
            check32("bp_value_hold", signed_int_val, 32'h0000_007B);
            check32("bp_ovf_hold", {31'd0, ovf}, 32'd0);
            check32("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check32("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check32("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check32("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); tick(); tick();
        check32("bp_ignored_input", {31'd0, out_valid}, 32'd0);
        drain();

        // Reset in the middle of a shift sequence
        send(32'h4F32_D05E, 32'h7FFF_FFFF, 1'b1, 1);
        drain();
        in_valid = 1'b1;
        FP_val = 32'h3F80_0000;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check32("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        check32("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check32("midreset_value", signed_int_val, 32'd0);
        check32("midreset_ovf", {31'd0, ovf}, 32'd0);
        for (int k = 0; k < 10; k++) tick();
        check32("midreset_no_output", {31'd0, out_valid}, 32'd0);

        // Random operands against the real-valued reference
        for (int k = 0; k < 100; k++) begin
            fp = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 160)), 23'($urandom())};
            ref_model(fp, rv, ro, rl);
            send(fp, rv, ro, rl);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
